mem_tgen: RTL and testbench
===========================

Name: mem_tgen

Overview:
- Self-checking traffic generator acting as a burst initiator on the main-memory port protocol (addr, burst_len, rd/wr, waitrequest, rd_valid).
- Drives the memory model directly, or drives one client port of mem_arb.
- On start, writes a deterministic pattern over a region in full-length bursts, reads the region back, compares every beat, and reports errors.
- Used for memory/arbiter bring-up without the CPU or caches.

Parameters:
ADDR_WIDTH, 32, byte-address width of mm_addr
DATA_WIDTH, 32, beat width; byte stride per beat = DATA_WIDTH/8
BURSTLEN_WIDTH, 2, width of mm_burst_len; beats per burst = burst_len+1
CNT_WIDTH, 16, width of num_bursts and err_count
TIMEOUT_CYCLES, 1024, watchdog limit (optional feature only)

Ports:
clock  in  1  system clock
reset_n  in  1  reset
start  in  1  one-cycle pulse; begins a run when idle
base_addr  in  ADDR_WIDTH  region start byte address; sampled at start
num_bursts  in  CNT_WIDTH  bursts in region; sampled at start
seed  in  DATA_WIDTH  pattern seed; sampled at start
mm_addr  out  ADDR_WIDTH  burst start byte address
mm_burst_len  out  BURSTLEN_WIDTH  beats-1
mm_wr_data  out  DATA_WIDTH  write beat data
mm_wr  out  1  write request/beat valid
mm_rd  out  1  read burst request
mm_waitrequest  in  1  slave stall
mm_rd_data  in  DATA_WIDTH  read beat data
mm_rd_valid  in  1  read beat valid
busy  out  1  run in progress
done  out  1  sticky run-complete flag
err_count  out  CNT_WIDTH  mismatching beats, saturating
first_err_addr  out  ADDR_WIDTH  byte address of first mismatch
timeout  out  1  watchdog fired (optional feature only)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clock, reset_n).
- Reset clears all outputs and state to 0 immediately, including mid-burst; the outstanding transaction is abandoned; the FSM returns to IDLE.
- Constants:
  - BEATS = 2^BURSTLEN_WIDTH; mm_burst_len is always all-ones.
  - Burst k start address = base + k*BEATS*(DATA_WIDTH/8).
  - Beat j address = burst start + j*(DATA_WIDTH/8).
- Pattern: expected/write data = beat byte address (zero-extended/truncated to DATA_WIDTH) XOR seed.
- FSM states: IDLE, WR, RD_CMD, RD_DATA, DONE.
- IDLE:
  - start=1 samples inputs, clears done/err_count/first_err_addr, sets busy next cycle.
  - num_bursts=0 goes directly to DONE.
  - Otherwise go to WR, burst 0.
- WR:
  - mm_wr held high for all BEATS beats, no gaps; mm_addr holds the burst start address.
  - A beat is accepted on a cycle with mm_wr && !mm_waitrequest; mm_wr_data advances the next cycle.
  - After the last beat of the last burst, go to RD_CMD, burst 0.
  - Bursts may be issued back-to-back.
- RD_CMD:
  - mm_rd=1 with burst address until a cycle with !mm_waitrequest; then mm_rd=0 next cycle and go to RD_DATA.
  - Exactly one read burst is outstanding at a time.
- RD_DATA:
  - Each mm_rd_valid beat is compared with the expected value in order.
  - On mismatch: err_count increments (saturating at all-ones); first_err_addr is captured only when err_count was 0.
  - After BEATS beats: go to the next burst's RD_CMD, or DONE after the last burst.
- rd_valid outside RD_DATA is ignored.
- DONE: busy=0, done=1 (sticky); go to IDLE. done stays high until the next accepted start.
- start while busy is ignored.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- No request is issued outside WR/RD_CMD: mm_wr=mm_rd=0 otherwise.

Optional Feature:
- Macro MEM_TGEN_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in RD_CMD/RD_DATA, reset on each accepted command or rd_valid beat.
  - On reaching TIMEOUT_CYCLES: set timeout=1 (sticky until next start), force err_count to at least 1, go to DONE.
  - Any late rd_valid after the timeout is ignored.
- Undefined: no counter, no timeout port; the bench hangs on a missing beat.

Test Plan:
- Clean run: base=0x1000, num_bursts=4, seed=0, zero-wait memory.
  - Expect 16 write beats with data 0x1000..0x103C, then 4 read bursts.
  - done=1, err_count=0, busy low one cycle after the last beat.
- Backpressure: mm_waitrequest random 50% throughout.
  - Write data and addresses stay held while stalled; identical memory contents; err_count=0.
- Corruption: bench flips bit 0 of read beats at 0x2008 and 0x2010, with base=0x2000, seed=0xA5A5A5A5, num_bursts=2.
  - Expect err_count=2, first_err_addr=0x2008.
- num_bursts=0 → no mm_wr/mm_rd ever asserted; done=1 two cycles after start.
- Reset mid-WR: assert reset_n=0 on beat 2 of burst 1.
  - All outputs go to 0 immediately.
  - A new start runs cleanly with err_count=0.
- Timeout (MEM_TGEN_TIMEOUT_EN, TIMEOUT_CYCLES=16): memory drops the last read beat.
  - Expect timeout=1, err_count≥1, done=1 within 16 cycles; start is ignored while busy.

Source files
------------

// File: rtl/mem_tgen.sv
// -----------------------------------------------------------------------------
// mem_tgen -- self-checking memory traffic generator (burst initiator)
//
// On a start pulse it writes a deterministic pattern over a region in
// full-length bursts, reads the whole region back one burst at a time, and
// compares every returned beat against the pattern.
//
// Pattern: data of a beat = (beat byte address, resized to DATA_WIDTH) ^ seed.
// Burst k starts at base + k*BEATS*(DATA_WIDTH/8); addresses wrap.
//
// Handshake rules on the memory side:
//   - A write beat transfers on any cycle with mm_wr && !mm_waitrequest.
//     mm_addr holds the burst start address for the whole burst, and
//     mm_wr_data advances to the next beat the cycle after a transfer.
//   - A read command transfers on any cycle with mm_rd && !mm_waitrequest.
//     Beats come back as mm_rd_valid pulses that cannot be stalled. Only
//     one read burst is outstanding at a time.
//   - mm_wr and mm_rd are never high outside the write / read-command states.
//
// Ports:
//   clock, reset_n       clock, asynchronous active-low reset
//   start                one-cycle pulse, accepted only when idle
//   base_addr            region start byte address (sampled at start)
//   num_bursts           bursts in the region (sampled at start)
//   seed                 pattern seed (sampled at start)
//   mm_addr              burst start byte address
//   mm_burst_len         beats-1, always all-ones
//   mm_wr_data, mm_wr    write beat data / write request
//   mm_rd                read burst request
//   mm_waitrequest       slave stall
//   mm_rd_data/_valid    read beat return
//   busy                 run in progress
//   done                 sticky run-complete flag (cleared by next start)
//   err_count            mismatching beats, saturating
//   first_err_addr       byte address of the first mismatching beat
//   timeout              read watchdog fired (only with MEM_TGEN_TIMEOUT_EN)
//
// Optional build macro: MEM_TGEN_TIMEOUT_EN adds a read watchdog of
// TIMEOUT_CYCLES cycles and the timeout output.
// -----------------------------------------------------------------------------
module mem_tgen #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BURSTLEN_WIDTH = 2,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [CNT_WIDTH-1:0]      num_bursts,
    input  logic [DATA_WIDTH-1:0]     seed,
    output logic [ADDR_WIDTH-1:0]     mm_addr,
    output logic [BURSTLEN_WIDTH-1:0] mm_burst_len,
    output logic [DATA_WIDTH-1:0]     mm_wr_data,
    output logic                      mm_wr,
    output logic                      mm_rd,
    input  logic                      mm_waitrequest,
    input  logic [DATA_WIDTH-1:0]     mm_rd_data,
    input  logic                      mm_rd_valid,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_WIDTH-1:0]      err_count,
    output logic [ADDR_WIDTH-1:0]     first_err_addr
`ifdef MEM_TGEN_TIMEOUT_EN
    ,
    output logic                      timeout
`endif
);

    localparam int unsigned BYTE_SHIFT  = $clog2(DATA_WIDTH / 8);
    localparam int unsigned BURST_SHIFT = BYTE_SHIFT + BURSTLEN_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_CMD,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0]     base_q;
    logic [CNT_WIDTH-1:0]      nb_q;
    logic [DATA_WIDTH-1:0]     seed_q;
    logic [CNT_WIDTH-1:0]      burst_idx;
    logic [BURSTLEN_WIDTH-1:0] beat_idx;

    logic [ADDR_WIDTH-1:0] burst_addr;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [DATA_WIDTH-1:0] pattern;
    logic                  last_beat;
    logic                  last_burst;
    logic                  wr_acc;
    logic                  beat_acc;
    logic                  mismatch;
    logic                  wd_fire;

    assign burst_addr = base_q + (ADDR_WIDTH'(burst_idx) << BURST_SHIFT);
    assign beat_addr  = burst_addr + (ADDR_WIDTH'(beat_idx) << BYTE_SHIFT);
    // Same value serves as write data and as the expected read data.
    assign pattern    = DATA_WIDTH'(beat_addr) ^ seed_q;
    assign last_beat  = (beat_idx == {BURSTLEN_WIDTH{1'b1}});
    assign last_burst = (burst_idx == nb_q - CNT_WIDTH'(1));
    assign mismatch   = (mm_rd_data != pattern);

    assign mm_burst_len = {BURSTLEN_WIDTH{1'b1}};

`ifdef MEM_TGEN_TIMEOUT_EN
    localparam int unsigned WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_WIDTH-1:0] wd_cnt;
    logic                wd_waiting;

    // The watchdog only counts cycles spent waiting for the slave: a stalled
    // read command or a gap between read beats.
    assign wd_waiting = (state_q == S_RD_CMD  && mm_waitrequest) ||
                        (state_q == S_RD_DATA && !mm_rd_valid);
    assign wd_fire    = wd_waiting && (wd_cnt == WD_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (wd_waiting && !wd_fire) begin
            wd_cnt <= wd_cnt + WD_WIDTH'(1);
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    localparam int unsigned timeout_cycles_unused = TIMEOUT_CYCLES;
    assign wd_fire = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and memory-side outputs
    always_comb begin
        state_d    = state_q;
        wr_acc     = 1'b0;
        beat_acc   = 1'b0;
        mm_wr      = 1'b0;
        mm_rd      = 1'b0;
        mm_addr    = '0;
        mm_wr_data = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_bursts == '0) ? S_DONE : S_WR;
                end
            end
            S_WR: begin
                mm_wr      = 1'b1;
                mm_addr    = burst_addr;
                mm_wr_data = pattern;
                if (!mm_waitrequest) begin
                    wr_acc = 1'b1;
                    if (last_beat && last_burst) begin
                        state_d = S_RD_CMD;
                    end
                end
            end
            S_RD_CMD: begin
                mm_rd   = 1'b1;
                mm_addr = burst_addr;
                if (!mm_waitrequest) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (mm_rd_valid) begin
                    beat_acc = 1'b1;
                    if (last_beat) begin
                        state_d = last_burst ? S_DONE : S_RD_CMD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (wd_fire) begin
            state_d = S_DONE;
        end
    end

    // Run context, beat/burst counters and result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_q         <= '0;
            nb_q           <= '0;
            seed_q         <= '0;
            burst_idx      <= '0;
            beat_idx       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
`ifdef MEM_TGEN_TIMEOUT_EN
            timeout        <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q         <= base_addr;
                        nb_q           <= num_bursts;
                        seed_q         <= seed;
                        burst_idx      <= '0;
                        beat_idx       <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
`ifdef MEM_TGEN_TIMEOUT_EN
                        timeout        <= 1'b0;
`endif
                    end
                end
                S_WR: begin
                    if (wr_acc) begin
                        // beat_idx wraps to 0 naturally after the last beat
                        beat_idx <= beat_idx + BURSTLEN_WIDTH'(1);
                        if (last_beat) begin
                            burst_idx <= last_burst ? '0 : burst_idx + CNT_WIDTH'(1);
                        end
                    end
                end
                S_RD_DATA: begin
                    if (beat_acc) begin
                        beat_idx <= beat_idx + BURSTLEN_WIDTH'(1);
                        if (last_beat) begin
                            burst_idx <= burst_idx + CNT_WIDTH'(1);
                        end
                        if (mismatch) begin
                            if (err_count != '1) begin
                                err_count <= err_count + CNT_WIDTH'(1);
                            end
                            if (err_count == '0) begin
                                first_err_addr <= beat_addr;
                            end
                        end
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
`ifdef MEM_TGEN_TIMEOUT_EN
            // A lost beat must always show up as at least one error.
            if (wd_fire) begin
                timeout <= 1'b1;
                if (err_count == '0) begin
                    err_count <= CNT_WIDTH'(1);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_tgen.sv
module tb_mem_tgen;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BLW   = 2;
  localparam int CW    = 16;
  localparam int TO    = 16;
  localparam int BEATS = 4;
  localparam int BYTES = 4;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           start = 1'b0;
  logic [AW-1:0]  base_addr = '0;
  logic [CW-1:0]  num_bursts = '0;
  logic [DW-1:0]  seed = '0;
  logic [AW-1:0]  mm_addr;
  logic [BLW-1:0] mm_burst_len;
  logic [DW-1:0]  mm_wr_data;
  logic           mm_wr;
  logic           mm_rd;
  logic           mm_waitrequest = 1'b0;
  logic [DW-1:0]  mm_rd_data = '0;
  logic           mm_rd_valid = 1'b0;
  logic           busy;
  logic           done;
  logic [CW-1:0]  err_count;
  logic [AW-1:0]  first_err_addr;
`ifdef MEM_TGEN_TIMEOUT_EN
  logic           timeout;
`endif

  mem_tgen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BLW),
    .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clk), .reset_n(rst_n), .start(start),
    .base_addr(base_addr), .num_bursts(num_bursts), .seed(seed),
    .mm_addr(mm_addr), .mm_burst_len(mm_burst_len), .mm_wr_data(mm_wr_data),
    .mm_wr(mm_wr), .mm_rd(mm_rd), .mm_waitrequest(mm_waitrequest),
    .mm_rd_data(mm_rd_data), .mm_rd_valid(mm_rd_valid),
    .busy(busy), .done(done), .err_count(err_count),
    .first_err_addr(first_err_addr)
`ifdef MEM_TGEN_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] base;
    int          nb;
    logic [31:0] seed;
    int          wait_pct;
    logic [31:0] c0;
    logic [31:0] c1;
    bit          drop;
    bit          poke;
    int          exp_err;
    logic [31:0] exp_first;
    bit          exp_to;
  } vec_t;

  vec_t vecs[$];

  logic [63:0] exp_q[$];            // {byte addr, data} of every expected write beat
  logic [31:0] rd_q[$];             // beat addresses still to be returned
  logic [31:0] mem [logic [31:0]];

  int          wait_pct = 0;
  logic [31:0] c0 = NONE;
  logic [31:0] c1 = NONE;
  logic [31:0] cur_seed = '0;
  int          cur_nb = 0;
  bit          drop_last = 0;
  bit          spurious = 0;
  int          wr_beat = 0;
  int          wr_seen = 0;
  int          rd_cmds = 0;
  int          req_seen = 0;
  int          last_beat_cyc = 0;
  bit          stalled_wr = 0;
  logic [31:0] st_addr, st_data;
  logic [31:0] a_w;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] w;
    if (mem.exists(a)) w = mem[a];
    else w = a ^ cur_seed ^ 32'h0F0F_0001;
    if (a == c0 || a == c1) w[0] = ~w[0];
    return w;
  endfunction

  // Reference model: walk the region beat by beat in read order.
  function automatic void model(input vec_t v, output int errs, output logic [31:0] first);
    logic [31:0] a;
    errs = 0;
    first = '0;
    for (int i = 0; i < v.nb * BEATS; i++) begin
      a = v.base + 32'(i * BYTES);
      if (a == v.c0 || a == v.c1) begin
        if (errs == 0) first = a;
        errs++;
      end
    end
  endfunction

  // ---------------- memory slave model ----------------
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (mm_wr || mm_rd) req_seen++;
      if (mm_wr && mm_rd) chk("wr_rd_both", 1, 0);
      if (mm_wr) begin
        if (stalled_wr) chk("wr_hold", {mm_addr, mm_wr_data}, {st_addr, st_data});
        if (!mm_waitrequest) begin
          a_w = mm_addr + 32'(wr_beat * BYTES);
          mem[a_w] = mm_wr_data;
          if (exp_q.size() == 0) chk("wr_extra", {a_w, mm_wr_data}, 64'h0);
          else chk("wr_beat", {a_w, mm_wr_data}, exp_q.pop_front());
          wr_beat = (wr_beat + 1) % BEATS;
          wr_seen++;
          stalled_wr = 0;
        end else begin
          stalled_wr = 1;
          st_addr = mm_addr;
          st_data = mm_wr_data;
        end
      end else begin
        stalled_wr = 0;
      end
      if (mm_rd && !mm_waitrequest) begin
        chk("one_outstanding", {31'd0, (rd_q.size() == 0 && !mm_rd_valid)}, 1);
        chk("burst_len", mm_burst_len, 2'b11);
        rd_cmds++;
        for (int j = 0; j < BEATS; j++) begin
          if (!(drop_last && rd_cmds == cur_nb && j == BEATS - 1))
            rd_q.push_back(mm_addr + 32'(j * BYTES));
        end
      end
      if (mm_rd_valid && !spurious) last_beat_cyc = cyc;
    end
    #1;
    if (!rst_n) begin
      mm_waitrequest = 1'b0;
      mm_rd_valid = 1'b0;
      mm_rd_data = '0;
    end else begin
      mm_waitrequest = ($urandom_range(99) < wait_pct);
      if (spurious) begin
        mm_rd_valid = 1'b1;
        mm_rd_data = $urandom;
      end else if (rd_q.size() > 0 && $urandom_range(99) >= wait_pct) begin
        mm_rd_valid = 1'b1;
        mm_rd_data = rd_word(rd_q.pop_front());
      end else begin
        mm_rd_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic arm(input vec_t v);
    exp_q.delete();
    rd_q.delete();
    mem.delete();
    for (int i = 0; i < v.nb * BEATS; i++) begin
      logic [31:0] a;
      a = v.base + 32'(i * BYTES);
      exp_q.push_back({a, a ^ v.seed});
    end
    wait_pct = v.wait_pct;
    c0 = v.c0;
    c1 = v.c1;
    cur_seed = v.seed;
    cur_nb = v.nb;
    drop_last = v.drop;
    wr_beat = 0;
    wr_seen = 0;
    rd_cmds = 0;
    req_seen = 0;
    stalled_wr = 0;
  endtask

  task automatic pulse_start(input vec_t v);
    @(negedge clk);
    base_addr = v.base;
    num_bursts = 16'(v.nb);
    seed = v.seed;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base_addr = $urandom;
    num_bursts = 16'($urandom);
    seed = $urandom;
  endtask

  task automatic run_case(input vec_t v);
    int n;
    int done_cyc;
    arm(v);
    pulse_start(v);
    chk("busy_set", busy, 1);
    chk("done_clr", done, 0);
    if (v.poke) begin
      repeat (2) @(negedge clk);
      base_addr = 32'h9000;
      num_bursts = 16'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 300 + v.nb * 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      chk("done_wait", done, 1);
    end else begin
      done_cyc = cyc;
      chk("err_count", err_count, 16'(v.exp_err));
      chk("first_err_addr", first_err_addr, v.exp_first);
      chk("busy_end", busy, 0);
      chk("wr_count", wr_seen, v.nb * BEATS);
      chk("wr_left", exp_q.size(), 0);
      chk("rd_cmds", rd_cmds, v.nb);
      chk("idle_req", {mm_wr, mm_rd}, 2'b00);
      if (v.drop) chk("to_latency", {31'd0, (done_cyc - last_beat_cyc <= TO + 2)}, 1);
      else chk("done_latency", done_cyc - last_beat_cyc, 1);
`ifdef MEM_TGEN_TIMEOUT_EN
      chk("timeout", timeout, v.exp_to);
`endif
    end
  endtask

  function automatic vec_t mk(input logic [31:0] base, input int nb, input logic [31:0] sd,
                              input int wp, input logic [31:0] x0, input logic [31:0] x1,
                              input bit drop, input bit poke, input int ee,
                              input logic [31:0] ef, input bit eto);
    vec_t v;
    v.base = base; v.nb = nb; v.seed = sd; v.wait_pct = wp; v.c0 = x0; v.c1 = x1;
    v.drop = drop; v.poke = poke; v.exp_err = ee; v.exp_first = ef; v.exp_to = eto;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    vec_t v;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first", first_err_addr, 0);
    chk("rst_req", {mm_wr, mm_rd}, 2'b00);
    chk("rst_addr", mm_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // table: inputs and expected results
    vecs.push_back(mk(32'h0000_1000, 4, 32'h0000_0000, 0,  NONE, NONE, 0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(32'h0000_1000, 4, 32'h1234_5678, 50, NONE, NONE, 0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(32'h0000_2000, 2, 32'hA5A5_A5A5, 0,  32'h2008, 32'h2010, 0, 0, 2, 32'h2008, 0));
    vecs.push_back(mk(32'hFFFF_FFF0, 2, 32'hDEAD_BEEF, 30, 32'h0004, NONE, 0, 0, 1, 32'h0004, 0));
    vecs.push_back(mk(32'h0000_0100, 3, 32'h0F0F_0F0F, 50, 32'h0110, 32'h0104, 0, 1, 2, 32'h0104, 0));
`ifdef MEM_TGEN_TIMEOUT_EN
    vecs.push_back(mk(32'h0000_4000, 1, 32'h0000_0055, 0,  NONE, NONE, 1, 0, 1, 32'h0, 1));
    vecs.push_back(mk(32'h0000_4000, 2, 32'h0000_0055, 20, 32'h4004, NONE, 1, 0, 1, 32'h4004, 1));
`endif
    for (int i = 0; i < 6; i++) begin
      int ee;
      logic [31:0] ef;
      v.base = $urandom & 32'hFFFF_FFFC;
      v.nb = $urandom_range(1, 5);
      v.seed = $urandom;
      v.wait_pct = $urandom_range(0, 60);
      v.c0 = ($urandom_range(1) == 1) ? v.base + 32'($urandom_range(0, v.nb * BEATS - 1) * BYTES) : NONE;
      v.c1 = ($urandom_range(1) == 1) ? v.base + 32'($urandom_range(0, v.nb * BEATS - 1) * BYTES) : NONE;
      v.drop = 0;
      v.poke = 0;
      v.exp_to = 0;
      model(v, ee, ef);
      v.exp_err = ee;
      v.exp_first = ef;
      vecs.push_back(v);
    end
    foreach (vecs[i]) run_case(vecs[i]);

    // rd_valid while idle must not disturb the previous result
    run_case(vecs[2]);
    spurious = 1;
    repeat (5) @(negedge clk);
    spurious = 0;
    repeat (2) @(negedge clk);
    chk("spurious_err", err_count, 2);
    chk("spurious_first", first_err_addr, 32'h2008);
    chk("spurious_done", done, 1);

    // num_bursts = 0: no requests, done two cycles after start
    v = mk(32'h0000_5000, 0, 32'h1, 0, NONE, NONE, 0, 0, 0, 32'h0, 0);
    arm(v);
    pulse_start(v);
    chk("nb0_busy", busy, 1);
    chk("nb0_done_early", done, 0);
    @(negedge clk);
    chk("nb0_done", done, 1);
    chk("nb0_busy_end", busy, 0);
    repeat (3) @(negedge clk);
    chk("nb0_no_req", req_seen, 0);
    chk("nb0_err", err_count, 0);

    // reset in the middle of burst 1, beat 2
    v = mk(32'h0000_3000, 4, 32'h0BAD_F00D, 0, NONE, NONE, 0, 0, 0, 32'h0, 0);
    arm(v);
    pulse_start(v);
    n = 0;
    while (wr_seen < 6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_wr_reached", wr_seen, 6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {mm_wr, mm_rd}, 2'b00);
    chk("mid_rst_addr", mm_addr, 0);
    chk("mid_rst_data", mm_wr_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    exp_q.delete();
    rd_q.delete();
    wr_beat = 0;
    stalled_wr = 0;
    rst_n = 1'b1;
    @(negedge clk);
    run_case(mk(32'h0000_3000, 4, 32'h0BAD_F00D, 25, NONE, NONE, 0, 0, 0, 32'h0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
